mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Parametrised multi-cycle CPU control unit and successor to the current fetch/decode/ALU/writeback controller. It adds load/store with a memory ready handshake and timeout, branch/link, an undefined-instruction trap, compare-without-writeback and a retired-instruction counter. It sits between the instruction register/decoder and the datapath (register file, A/B/C/F latches, shifter, ALU, PC, MDR).

Parameters:
ALU_OP_W, 4, ALU opcode width; compare ops are 4'b1000..4'b1011 (TST/TEQ/CMP/CMN).
SHIFT_OP_W, 3, shifter opcode width.
MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ready; 0 disables the timeout.
CNT_W, 32, retired-instruction counter width.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ir_valid  in  1  fetched instruction word valid
instr_class  in  2  00 DP, 01 MEM, 10 BRANCH, 11 UNDEF
mem_load  in  1  MEM class: 1 load, 0 store
link  in  1  BRANCH class: write link register
cond_pass  in  1  condition code satisfied
rm_imm_s  in  1  shifter operand select
rs_imm_s  in  2  shift amount select
shift_op  in  SHIFT_OP_W  shifter op
alu_op  in  ALU_OP_W  ALU op
s_bit  in  1  update flags
mem_ready  in  1  data memory done
write_pc, write_ir, write_reg, la, lb, lc, lf  out  1  datapath strobes
pc_src  out  1  0 = PC+4, 1 = branch target
reg_src  out  2  00 ALU, 01 MDR, 10 link PC
mem_req, mem_we, ld_mdr  out  1  data memory request, write enable, MDR load
rm_imm_s_ctrl  out  1 ; rs_imm_s_ctrl  out  2 ; shift_op_ctrl  out  SHIFT_OP_W ; alu_op_ctrl  out  ALU_OP_W ; s_ctrl  out  1  latched operation fields
undef_trap, mem_err  out  1  one-cycle event pulses
retire_cnt  out  CNT_W  retired-instruction count
state  out  4  current state, for debug

Behaviour:
- State register and latched fields reset asynchronously on rst=1: state=IDLE; latched fields, retire_cnt and the wait counter = 0. Reset mid-operation aborts with no pending strobe.
- Strobes are combinational decodes of the registered state (plus ir_valid/mem_ready where noted). All are 0 in IDLE and whenever not listed below.
- IDLE -> FETCH unconditionally.
- FETCH: write_pc = write_ir = ir_valid, pc_src=0. ir_valid=1 -> DECODE, else stay.
- DECODE: la=lb=lc=1.
  - cond_pass=0 -> FETCH; the instruction retires.
  - cond_pass=1: DP or MEM -> EXEC; BRANCH -> BRANCH; UNDEF -> TRAP.
  - Latch rm_imm_s, rs_imm_s, shift_op, alu_op on this cycle's edge. Latch s_ctrl = s_bit & (class==DP).
- EXEC: lf = s_ctrl. Latched fields are held until the next DECODE exit.
  - DP with compare alu_op -> FETCH (retire).
  - Other DP -> WB.
  - MEM -> MEM; the wait counter clears to 0.
- WB: write_reg=1, reg_src=00 -> FETCH (retire).
- MEM: mem_req=1, mem_we=~mem_load_q, where mem_load is latched at DECODE. The wait counter increments each cycle in MEM.
  - mem_ready=1, load: ld_mdr=1 this cycle -> MEMWB.
  - mem_ready=1, store -> FETCH (retire).
  - mem_ready=0 and counter==MEM_TIMEOUT-1 (MEM_TIMEOUT>0) -> ERR.
  - mem_ready and timeout in the same cycle: ready wins.
- MEMWB: write_reg=1, reg_src=01 -> FETCH (retire).
- BRANCH: write_pc=1, pc_src=1, write_reg=link_q, reg_src=10 -> FETCH (retire).
- TRAP: undef_trap=1 -> FETCH; no retire.
- ERR: mem_err=1 -> FETCH; no retire.
- Illegal state encoding -> FETCH.
- retire_cnt increments by 1 on each retire edge and wraps modulo 2^CNT_W.
- Latency from fetch-accept cycle to FETCH:
  - DP: 4 cycles.
  - Compare: 3 cycles.
  - Load: 5+w cycles (w = wait cycles).
  - Store: 4+w cycles.
  - Branch: 3 cycles.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings: IDLE, FETCH, DECODE, EXEC, WB, MEM, MEMWB, BRANCH, TRAP, ERR;
  - instr_class codes;
  - reg_src codes;
  - compare-op range constants;
  - function is_compare(alu_op).
- One sub-module, mem_wait_timer: a clear/enable counter with a terminal flag, width $clog2(MEM_TIMEOUT+1), terminal flag forced 0 when MEM_TIMEOUT=0.

Test Plan:
- Reset, then DP ADD (alu_op=0100, s_bit=1, cond_pass=1), ir_valid high -> states FETCH, DECODE, EXEC (lf=1), WB (write_reg=1, reg_src=00), FETCH; retire_cnt 0->1; alu_op_ctrl=0100 from EXEC onward.
- CMP (alu_op=1010) -> EXEC then FETCH with no write_reg; s_bit=1 gives lf=1 in EXEC; retire_cnt +1.
- Load with mem_ready after 3 MEM cycles -> mem_req=1 and mem_we=0 for 3 cycles, ld_mdr=1 on the 3rd, then MEMWB write_reg=1 with reg_src=01.
- Store with mem_ready never asserted, MEM_TIMEOUT=15 -> exactly 15 MEM cycles with mem_we=1, one-cycle mem_err, FETCH; retire_cnt unchanged. Rerun with mem_ready asserted on cycle 15: completes normally, no mem_err.
- BL (class 10, link=1) -> BRANCH with write_pc=1, pc_src=1, write_reg=1, reg_src=10. cond_pass=0 instead -> DECODE then FETCH, no strobes, retire_cnt +1. Class 11 -> undef_trap pulse, no retire.
- rst asserted mid-MEM -> state=IDLE and all strobes 0 immediately (asynchronous), retire_cnt=0. CNT_W=4 after 16 retires -> retire_cnt wraps to 0.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types for the multi-cycle control unit: state encodings, instruction classes,
// register-file source selects, the compare-op range and the datapath strobe bundle.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_WB     = 4'd4,
    ST_MEM    = 4'd5,
    ST_MEMWB  = 4'd6,
    ST_BRANCH = 4'd7,
    ST_TRAP   = 4'd8,
    ST_ERR    = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    CLS_DP     = 2'b00,
    CLS_MEM    = 2'b01,
    CLS_BRANCH = 2'b10,
    CLS_UNDEF  = 2'b11
  } instr_class_t;

  localparam logic [1:0] REG_SRC_ALU  = 2'b00;
  localparam logic [1:0] REG_SRC_MDR  = 2'b01;
  localparam logic [1:0] REG_SRC_LINK = 2'b10;

  // TST/TEQ/CMP/CMN occupy 4'b1000..4'b1011 and never write a result back
  localparam int unsigned CMP_OP_LO = 32'd8;
  localparam int unsigned CMP_OP_HI = 32'd11;

  typedef struct packed {
    logic       write_pc;
    logic       write_ir;
    logic       write_reg;
    logic       la;
    logic       lb;
    logic       lc;
    logic       lf;
    logic       pc_src;
    logic [1:0] reg_src;
    logic       mem_req;
    logic       mem_we;
    logic       ld_mdr;
    logic       undef_trap;
    logic       mem_err;
  } strobe_t;

  function automatic logic is_compare(input int unsigned op);
    return (op >= CMP_OP_LO) && (op <= CMP_OP_HI);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Decoder/datapath-facing bundle of the control unit; master is the controller, slave the
// decoder+datapath side. No flow control beyond ir_valid and mem_ready.
interface mc_ctrl_if #(
  parameter int ALU_OP_W   = 4,
  parameter int SHIFT_OP_W = 3,
  parameter int CNT_W      = 32
);
  import mc_ctrl_pkg::*;

  logic                  ir_valid;
  instr_class_t          instr_class;
  logic                  mem_load;
  logic                  link;
  logic                  cond_pass;
  logic                  rm_imm_s;
  logic [1:0]            rs_imm_s;
  logic [SHIFT_OP_W-1:0] shift_op;
  logic [ALU_OP_W-1:0]   alu_op;
  logic                  s_bit;
  logic                  mem_ready;

  logic                  write_pc;
  logic                  write_ir;
  logic                  write_reg;
  logic                  la;
  logic                  lb;
  logic                  lc;
  logic                  lf;
  logic                  pc_src;
  logic [1:0]            reg_src;
  logic                  mem_req;
  logic                  mem_we;
  logic                  ld_mdr;
  logic                  rm_imm_s_ctrl;
  logic [1:0]            rs_imm_s_ctrl;
  logic [SHIFT_OP_W-1:0] shift_op_ctrl;
  logic [ALU_OP_W-1:0]   alu_op_ctrl;
  logic                  s_ctrl;
  logic                  undef_trap;
  logic                  mem_err;
  logic [CNT_W-1:0]      retire_cnt;
  logic [3:0]            state;

  modport master (
    input  ir_valid, instr_class, mem_load, link, cond_pass, rm_imm_s, rs_imm_s,
           shift_op, alu_op, s_bit, mem_ready,
    output write_pc, write_ir, write_reg, la, lb, lc, lf, pc_src, reg_src,
           mem_req, mem_we, ld_mdr, rm_imm_s_ctrl, rs_imm_s_ctrl, shift_op_ctrl,
           alu_op_ctrl, s_ctrl, undef_trap, mem_err, retire_cnt, state
  );

  modport slave (
    output ir_valid, instr_class, mem_load, link, cond_pass, rm_imm_s, rs_imm_s,
           shift_op, alu_op, s_bit, mem_ready,
    input  write_pc, write_ir, write_reg, la, lb, lc, lf, pc_src, reg_src,
           mem_req, mem_we, ld_mdr, rm_imm_s_ctrl, rs_imm_s_ctrl, shift_op_ctrl,
           alu_op_ctrl, s_ctrl, undef_trap, mem_err, retire_cnt, state
  );

endinterface

// File: rtl/mc_ctrl_fsm_mem_wait_timer.sv
// Counts cycles spent waiting on data memory; term_o flags the last allowed wait cycle.
// Single-cycle clear/enable, term_o is a combinational decode of the count.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (MEM_TIMEOUT > 0) begin : g_term
      localparam logic [TW-1:0] TERM = TW'(MEM_TIMEOUT - 1);
      assign term_o = (cnt_q == TERM);
    end else begin : g_no_term
      assign term_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control FSM: fetch, decode, execute, writeback, load/store, branch and traps.
// DP 4 cycles, compare/branch 3, load 5+w, store 4+w; stalls in FETCH on ir_valid, in MEM on mem_ready.
module mc_ctrl_fsm #(
  parameter int ALU_OP_W    = 4,
  parameter int SHIFT_OP_W  = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic       clk,
  input logic       rst,
  mc_ctrl_if.master bus
);
  import mc_ctrl_pkg::*;

  state_t                state_q;
  state_t                state_d;
  instr_class_t          cls_q;
  logic                  mem_load_q;
  logic                  link_q;
  logic                  rm_imm_s_q;
  logic [1:0]            rs_imm_s_q;
  logic [SHIFT_OP_W-1:0] shift_op_q;
  logic [ALU_OP_W-1:0]   alu_op_q;
  logic                  s_q;
  logic [CNT_W-1:0]      retire_q;

  strobe_t strb;
  logic    retire;
  logic    mem_tmo;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_EXEC),
    .en_i  (state_q == ST_MEM),
    .term_o(mem_tmo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operation fields are captured on every DECODE exit so EXEC..WB see a stable copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q      <= CLS_DP;
      mem_load_q <= 1'b0;
      link_q     <= 1'b0;
      rm_imm_s_q <= 1'b0;
      rs_imm_s_q <= '0;
      shift_op_q <= '0;
      alu_op_q   <= '0;
      s_q        <= 1'b0;
    end else if (state_q == ST_DECODE) begin
      cls_q      <= bus.instr_class;
      mem_load_q <= bus.mem_load;
      link_q     <= bus.link;
      rm_imm_s_q <= bus.rm_imm_s;
      rs_imm_s_q <= bus.rs_imm_s;
      shift_op_q <= bus.shift_op;
      alu_op_q   <= bus.alu_op;
      s_q        <= bus.s_bit & (bus.instr_class == CLS_DP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_q <= '0;
    end else if (retire) begin
      retire_q <= retire_q + 1'b1;
    end
  end

  always_comb begin
    state_d = ST_FETCH;
    strb    = '0;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        strb.write_pc = bus.ir_valid;
        strb.write_ir = bus.ir_valid;
        state_d       = bus.ir_valid ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        strb.la = 1'b1;
        strb.lb = 1'b1;
        strb.lc = 1'b1;
        if (!bus.cond_pass) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end else begin
          case (bus.instr_class)
            CLS_DP, CLS_MEM: state_d = ST_EXEC;
            CLS_BRANCH:      state_d = ST_BRANCH;
            default:         state_d = ST_TRAP;
          endcase
        end
      end
      ST_EXEC: begin
        strb.lf = s_q;
        if (cls_q == CLS_MEM) begin
          state_d = ST_MEM;
        end else if (cls_q == CLS_DP && !is_compare(32'(alu_op_q))) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_WB: begin
        strb.write_reg = 1'b1;
        strb.reg_src   = REG_SRC_ALU;
        retire         = 1'b1;
      end
      ST_MEM: begin
        strb.mem_req = 1'b1;
        strb.mem_we  = ~mem_load_q;
        // A response arriving on the final allowed cycle still completes the access
        if (bus.mem_ready) begin
          if (mem_load_q) begin
            strb.ld_mdr = 1'b1;
            state_d     = ST_MEMWB;
          end else begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
        end else if (mem_tmo) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_MEMWB: begin
        strb.write_reg = 1'b1;
        strb.reg_src   = REG_SRC_MDR;
        retire         = 1'b1;
      end
      ST_BRANCH: begin
        strb.write_pc  = 1'b1;
        strb.pc_src    = 1'b1;
        strb.write_reg = link_q;
        strb.reg_src   = REG_SRC_LINK;
        retire         = 1'b1;
      end
      ST_TRAP: begin
        strb.undef_trap = 1'b1;
      end
      ST_ERR: begin
        strb.mem_err = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign bus.write_pc      = strb.write_pc;
  assign bus.write_ir      = strb.write_ir;
  assign bus.write_reg     = strb.write_reg;
  assign bus.la            = strb.la;
  assign bus.lb            = strb.lb;
  assign bus.lc            = strb.lc;
  assign bus.lf            = strb.lf;
  assign bus.pc_src        = strb.pc_src;
  assign bus.reg_src       = strb.reg_src;
  assign bus.mem_req       = strb.mem_req;
  assign bus.mem_we        = strb.mem_we;
  assign bus.ld_mdr        = strb.ld_mdr;
  assign bus.undef_trap    = strb.undef_trap;
  assign bus.mem_err       = strb.mem_err;
  assign bus.rm_imm_s_ctrl = rm_imm_s_q;
  assign bus.rs_imm_s_ctrl = rs_imm_s_q;
  assign bus.shift_op_ctrl = shift_op_q;
  assign bus.alu_op_ctrl   = alu_op_q;
  assign bus.s_ctrl        = s_q;
  assign bus.retire_cnt    = retire_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: stimulus queues one expected record per clock cycle,
// a negedge monitor pops and compares state, strobes and latched fields.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_if #(.ALU_OP_W(4), .SHIFT_OP_W(3), .CNT_W(4)) bus ();

  mc_ctrl_fsm #(
    .ALU_OP_W(4), .SHIFT_OP_W(3), .MEM_TIMEOUT(15), .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // strobe vector bits: wpc wir wreg la lb lc lf pcs reg_src[1:0] mreq mwe ldm ut me
  localparam logic [14:0] WPC = 15'h4000, WIR = 15'h2000, WREG = 15'h1000;
  localparam logic [14:0] LA = 15'h0800, LB = 15'h0400, LC = 15'h0200, LF = 15'h0100;
  localparam logic [14:0] PCS = 15'h0080, RS_LNK = 15'h0040, RS_MDR = 15'h0020;
  localparam logic [14:0] MREQ = 15'h0010, MWE = 15'h0008, LDM = 15'h0004;
  localparam logic [14:0] UT = 15'h0002, ME = 15'h0001;
  localparam logic [14:0] DEC = LA | LB | LC;

  typedef struct {
    state_t      st;
    logic [14:0] sb;
    logic [3:0]  rc;
    logic [3:0]  aop;
    logic [2:0]  sop;
    logic        sc;
    string       tag;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          step_id = 0;
  string       cur_tag = "reset";
  logic [3:0]  rc_exp = '0;
  logic [3:0]  aop_exp = '0;
  logic [2:0]  sop_exp = '0;
  logic        sc_exp = 1'b0;

  always @(negedge clk) begin
    exp_t        e;
    logic [14:0] a_sb;
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      a_sb = {bus.write_pc, bus.write_ir, bus.write_reg, bus.la, bus.lb, bus.lc, bus.lf,
              bus.pc_src, bus.reg_src, bus.mem_req, bus.mem_we, bus.ld_mdr,
              bus.undef_trap, bus.mem_err};
      n_cmp++;
      if (bus.state !== e.st || a_sb !== e.sb || bus.retire_cnt !== e.rc ||
          bus.alu_op_ctrl !== e.aop || bus.shift_op_ctrl !== e.sop || bus.s_ctrl !== e.sc) begin
        n_bad++;
        $display("FAIL %s step%0d: got state=%0d strb=%h cnt=%0d alu=%h sh=%h s=%b, want state=%0d strb=%h cnt=%0d alu=%h sh=%h s=%b",
                 e.tag, e.id, bus.state, a_sb, bus.retire_cnt, bus.alu_op_ctrl,
                 bus.shift_op_ctrl, bus.s_ctrl, e.st, e.sb, e.rc, e.aop, e.sop, e.sc);
      end
    end
  end

  task automatic step(input state_t st, input logic [14:0] sb);
    exp_t e;
    e.st  = st;
    e.sb  = sb;
    e.rc  = rc_exp;
    e.aop = aop_exp;
    e.sop = sop_exp;
    e.sc  = sc_exp;
    e.tag = cur_tag;
    e.id  = step_id;
    step_id++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Fetch-accept cycle followed by the DECODE cycle; fields latch on the DECODE exit edge
  task automatic fd(input instr_class_t c, input logic ld, input logic lk, input logic cp,
                    input logic [3:0] aop, input logic s, input logic [2:0] sop);
    bus.instr_class = c;
    bus.mem_load    = ld;
    bus.link        = lk;
    bus.cond_pass   = cp;
    bus.alu_op      = aop;
    bus.s_bit       = s;
    bus.shift_op    = sop;
    bus.ir_valid    = 1'b1;
    step(ST_FETCH, WPC | WIR);
    bus.ir_valid = 1'b0;
    step(ST_DECODE, DEC);
    aop_exp = aop;
    sop_exp = sop;
    sc_exp  = s & (c == CLS_DP);
    if (!cp) rc_exp++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ir_valid    = 1'b0;
    bus.instr_class = CLS_DP;
    bus.mem_load    = 1'b0;
    bus.link        = 1'b0;
    bus.cond_pass   = 1'b0;
    bus.rm_imm_s    = 1'b0;
    bus.rs_imm_s    = 2'b00;
    bus.shift_op    = 3'b000;
    bus.alu_op      = 4'b0000;
    bus.s_bit       = 1'b0;
    bus.mem_ready   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    step(ST_IDLE, '0);
    rst = 1'b0;
    step(ST_IDLE, '0);

    cur_tag = "stall";
    step(ST_FETCH, '0);

    cur_tag = "dp_add";
    fd(CLS_DP, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 3'b010);
    step(ST_EXEC, LF);
    step(ST_WB, WREG);
    rc_exp++;

    cur_tag = "cmp";
    fd(CLS_DP, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 3'b001);
    step(ST_EXEC, LF);
    rc_exp++;

    cur_tag = "tst_lo";
    fd(CLS_DP, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 3'b100);
    step(ST_EXEC, '0);
    rc_exp++;

    cur_tag = "op_below_cmp";
    fd(CLS_DP, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0, 3'b110);
    step(ST_EXEC, '0);
    step(ST_WB, WREG);
    rc_exp++;

    cur_tag = "op_above_cmp";
    fd(CLS_DP, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b1, 3'b101);
    step(ST_EXEC, LF);
    step(ST_WB, WREG);
    rc_exp++;

    cur_tag = "load";
    fd(CLS_MEM, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 3'b011);
    step(ST_EXEC, '0);
    step(ST_MEM, MREQ);
    step(ST_MEM, MREQ);
    bus.mem_ready = 1'b1;
    step(ST_MEM, MREQ | LDM);
    bus.mem_ready = 1'b0;
    step(ST_MEMWB, WREG | RS_MDR);
    rc_exp++;

    cur_tag = "store_timeout";
    fd(CLS_MEM, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 3'b000);
    step(ST_EXEC, '0);
    for (int i = 0; i < 15; i++) step(ST_MEM, MREQ | MWE);
    step(ST_ERR, ME);

    cur_tag = "store_ready15";
    fd(CLS_MEM, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 3'b001);
    step(ST_EXEC, '0);
    for (int i = 0; i < 14; i++) step(ST_MEM, MREQ | MWE);
    bus.mem_ready = 1'b1;
    step(ST_MEM, MREQ | MWE);
    bus.mem_ready = 1'b0;
    rc_exp++;

    cur_tag = "bl";
    fd(CLS_BRANCH, 1'b0, 1'b1, 1'b1, 4'b0011, 1'b0, 3'b010);
    step(ST_BRANCH, WPC | PCS | WREG | RS_LNK);
    rc_exp++;

    cur_tag = "b_nolink";
    fd(CLS_BRANCH, 1'b0, 1'b0, 1'b1, 4'b0101, 1'b0, 3'b011);
    step(ST_BRANCH, WPC | PCS | RS_LNK);
    rc_exp++;

    cur_tag = "cond_fail";
    fd(CLS_BRANCH, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b1, 3'b111);

    cur_tag = "undef";
    fd(CLS_UNDEF, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 3'b001);
    step(ST_TRAP, UT);

    cur_tag = "rst_mid_mem";
    fd(CLS_MEM, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 3'b101);
    step(ST_EXEC, '0);
    step(ST_MEM, MREQ);
    rst = 1'b1;
    #1;
    rc_exp  = '0;
    aop_exp = '0;
    sop_exp = '0;
    sc_exp  = 1'b0;
    step(ST_IDLE, '0);
    rst = 1'b0;
    step(ST_IDLE, '0);

    cur_tag = "wrap";
    for (int i = 0; i < 16; i++) begin
      fd(CLS_DP, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 3'b110);
      step(ST_EXEC, '0);
      rc_exp++;
    end
    step(ST_FETCH, '0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d records left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
